// File: rtl/line_buf_writer.sv
// Fill controller for a single-bit line buffer RAM: an optional clear sweep,
// then (x, value) pixel writes accepted over valid/ready, ending in a line_done pulse.
module line_buf_writer #(
  parameter int unsigned WIDTH          = 480,
  parameter int unsigned AW             = 9,
  parameter bit          CLEAR_ON_START = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          px_valid,
  output logic          px_ready,
  input  logic [AW-1:0] px_x,
  input  logic          px_val,
  input  logic          px_last,
  output logic          ram_in,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          busy,
  output logic          line_done,
  output logic [7:0]    oob_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] PLOT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH - 1);

  logic [1:0] state;
  logic       handshake;
  logic       in_range;

  assign handshake = px_valid & px_ready & (state == PLOT);
  assign in_range  = (32'(px_x) < WIDTH);

  // The clear sweep uses ram_addr itself as its counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ram_we    <= 1'b0;
      ram_in    <= 1'b0;
      ram_addr  <= '0;
      px_ready  <= 1'b0;
      busy      <= 1'b0;
      line_done <= 1'b0;
      oob_count <= 8'd0;
    end else begin
      line_done <= 1'b0;
      case (state)
        IDLE: begin
          ram_we <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            oob_count <= 8'd0;
            if (CLEAR_ON_START) begin
              state    <= CLEAR;
              ram_we   <= 1'b1;
              ram_in   <= 1'b0;
              ram_addr <= '0;
            end else begin
              state    <= PLOT;
              px_ready <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (ram_addr == LAST_ADDR) begin
            state    <= PLOT;
            ram_we   <= 1'b0;
            px_ready <= 1'b1;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
        PLOT: begin
          ram_we <= 1'b0;
          if (handshake) begin
            if (in_range) begin
              ram_we   <= 1'b1;
              ram_addr <= px_x;
              ram_in   <= px_val;
            end else if (oob_count != 8'hFF) begin
              oob_count <= oob_count + 8'd1;
            end
            // An out-of-range last pixel still closes the line.
            if (px_last) begin
              state    <= DONE;
              px_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          ram_we    <= 1'b0;
          state     <= IDLE;
          busy      <= 1'b0;
          line_done <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/line_buf_writer.md
Name: line_buf_writer

Overview:
- Upstream fill controller for the 480x1 single-bit line buffer RAM.
- On `start`, it optionally clears every buffer bit to 0, then accepts a stream of (x, value) pixel writes over a valid/ready handshake and drives the RAM's serial write port (`in`, `write_addr`, `we`).
- It signals `line_done` once the final write of the line has been committed, so downstream logic may consume the parallel RAM output.
- Out-of-range x coordinates are dropped and counted.

Parameters:
- WIDTH, 480, number of bits in the line buffer; valid x is 0..WIDTH-1.
- AW, 9, address width; must satisfy 2^AW >= WIDTH.
- CLEAR_ON_START, 1, if 1 a new line begins with a full clear sweep; if 0 the block goes straight to plotting.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  begin a new line; sampled only in IDLE, ignored otherwise.
- px_valid  input  1  pixel request valid.
- px_ready  output  1  block accepts a pixel this cycle; a handshake is px_valid & px_ready.
- px_x  input  AW  target bit index.
- px_val  input  1  bit value to write.
- px_last  input  1  marks the final pixel of the line; qualified by the handshake.
- ram_in  output  1  data to the RAM `in` port.
- ram_addr  output  AW  to the RAM `write_addr` port.
- ram_we  output  1  to the RAM `we` port.
- busy  output  1  high in any state other than IDLE.
- line_done  output  1  single-cycle pulse when the line is complete.
- oob_count  output  8  saturating count of dropped pixels (px_x >= WIDTH) since the last start.

Behaviour:
- All outputs are registered. State register encoding: IDLE, CLEAR, PLOT, DONE.
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - ram_we, ram_in, ram_addr, px_ready, busy, line_done, oob_count all = 0.
  - Reset asserted mid-CLEAR or mid-PLOT abandons the line; any partial RAM contents are left as they are.
- IDLE:
  - start=1 at edge t moves to CLEAR (CLEAR_ON_START=1) or PLOT (CLEAR_ON_START=0) at t+1.
  - The same start also zeroes oob_count.
- CLEAR:
  - An internal counter c runs 0..WIDTH-1.
  - Each CLEAR cycle drives ram_we=1, ram_in=0, ram_addr=c.
  - First clear write is visible in cycle t+1; address WIDTH-1 is visible in cycle t+WIDTH.
  - px_ready=0 throughout.
  - After c=WIDTH-1 the block enters PLOT, so px_ready=1 in cycle t+WIDTH+1.
- PLOT:
  - px_ready=1 except in the cycle after a px_last handshake.
  - A handshake at cycle k with px_x < WIDTH gives ram_we=1, ram_addr=px_x, ram_in=px_val in cycle k+1.
  - A handshake with px_x >= WIDTH gives ram_we=0 in k+1, and oob_count increments, saturating at 255.
  - Back-to-back handshakes give one write per cycle, with no bubbles.
  - Duplicate x values: the later write wins.
  - A handshake with px_last=1 moves to DONE at k+1; px_ready=0 from k+1.
- DONE:
  - Lasts exactly one cycle (k+1), during which the last pixel's write appears on the RAM port.
  - line_done=1 in cycle k+2 only; state IDLE and busy=0 in k+2.
  - A start in k+2 is accepted.
- ram_we is 0 in IDLE and in any PLOT cycle not preceded by a valid in-range handshake.
- ram_addr and ram_in hold their last values when ram_we=0; the consumer must ignore them in that case.
- start while busy is ignored, with no restart and no counter clear.
- px_valid in IDLE, CLEAR or DONE is not accepted; the requester must hold it until px_ready.
- A px_last on an out-of-range pixel still ends the line; it is counted and not written.

Test Plan:
1. Reset, then start=1 for one cycle with CLEAR_ON_START=1 -> 480 consecutive cycles of ram_we=1, ram_in=0, addresses 0..479 in order; px_ready rises the cycle after address 479; busy=1 throughout.
2. After clear, stream x=0,1,479 with val=1 back-to-back, last on x=479 -> ram_we pulses on three consecutive cycles with addresses 0, 1, 479; line_done one cycle after address 479 is written; RAM holds bits 0, 1, 479 = 1 and all others 0.
3. Pixels x=480 and x=511 inside a line -> no ram_we for them; oob_count=2; a following start resets oob_count to 0. Send 300 oob pixels -> oob_count=255.
4. start pulsed during CLEAR and during PLOT -> ignored; clear sequence unbroken; line_done appears only once.
5. rst driven to 0 asynchronously mid-CLEAR, at address 200 -> all outputs 0 immediately, without waiting for a clock edge; after release, IDLE with px_ready=0 until the next start.
6. CLEAR_ON_START=0, start then a single pixel x=5, val=1, with px_last=1 -> px_ready=1 the cycle after start; one write at addr 5; px_ready drops; line_done two cycles after the handshake.
